// File: rtl/drfm_pkg.sv
// Shared types and helpers for the DRFM playback reader.
package drfm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_ABORT = 3'd3,
        S_DONE  = 3'd4
    } drfm_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_OUT_W  = 8;
    localparam int LANES      = DEF_DATA_W / DEF_OUT_W;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/drfm_ring_buffer.sv
// Show-ahead ring buffer with fill count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module drfm_ring_buffer
    import drfm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_wr,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic                   i_rd,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [clog2(DEPTH):0]  o_fill,
    output logic                   o_empty
);
    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [PTR_W:0]    r_fill;
    logic              w_do_rd;

    assign w_do_rd = i_rd && (r_fill != '0);
    assign o_rdata = r_mem[r_rptr];
    assign o_fill  = r_fill;
    assign o_empty = (r_fill == '0);

    always_ff @(posedge i_clk) begin
        if (i_wr) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (i_wr)    r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_rd) r_rptr <= r_rptr + PTR_W'(1);
            case ({i_wr, w_do_rd})
                2'b10:   r_fill <= r_fill + (PTR_W+1)'(1);
                2'b01:   r_fill <= r_fill - (PTR_W+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/drfm_playback_reader.sv
// DRFM playback engine: Avalon-MM read master streaming [base, base+length)
// through a ring buffer, serialised into OUT_W-bit samples, low lane first.
module drfm_playback_reader
    import drfm_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 25,
    parameter int OUT_W     = 8,
    parameter int BUF_DEPTH = 512,
    parameter int MAX_PEND  = 8
) (
    input  logic                  M100CLK,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_length,
    input  logic                  cfg_loop,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int NLANES = DATA_W / OUT_W;
    localparam int LANE_W = (NLANES > 1) ? clog2(NLANES) : 1;
    localparam int PEND_W = clog2(MAX_PEND + 1);
    localparam int FILL_W = clog2(BUF_DEPTH) + 1;
    localparam int CRED_W = clog2(BUF_DEPTH + MAX_PEND + 1) + 1;

    drfm_state_t        r_state;
    logic [ADDR_W-1:0]  r_base, r_length, r_issued, r_avm_addr;
    logic               r_loop, r_avm_read, r_busy, r_done;
    logic [PEND_W-1:0]  r_pending;
    logic [LANE_W-1:0]  r_lane;

    logic w_live, w_stop, w_acc, w_hold, w_rdv_ok, w_wr, w_take, w_pop;
    logic w_last, w_more, w_cred_ok, w_issue, w_empty;
    logic [PEND_W-1:0]            w_pend_nx;
    logic [FILL_W-1:0]            w_fill;
    logic [CRED_W-1:0]            w_fill_nx;
    logic [ADDR_W-1:0]            w_iss_inc, w_issued_nx;
    logic [DATA_W-1:0]            w_rdata;
    logic [NLANES-1:0][OUT_W-1:0] w_lanes;

    assign w_live   = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_stop   = w_live && stop;
    assign w_acc    = r_avm_read && !avm_waitrequest;
    assign w_hold   = r_avm_read && avm_waitrequest;
    assign w_rdv_ok = avm_readdatavalid && (r_pending != '0);
    assign w_wr     = w_rdv_ok && w_live && !w_stop;

    always_comb begin
        w_pend_nx = r_pending;
        case ({w_acc, w_rdv_ok})
            2'b10:   w_pend_nx = r_pending + PEND_W'(1);
            2'b01:   w_pend_nx = r_pending - PEND_W'(1);
            default: w_pend_nx = r_pending;
        endcase
    end

    // Next-cycle credits: a request launched now must still fit once returned.
    assign w_fill_nx = CRED_W'(w_fill) + CRED_W'(w_wr);
    assign w_cred_ok = ((CRED_W'(w_pend_nx) + w_fill_nx) < CRED_W'(BUF_DEPTH)) &&
                       (w_pend_nx < PEND_W'(MAX_PEND));

    assign w_iss_inc   = r_issued + ADDR_W'(1);
    assign w_last      = w_acc && (w_iss_inc == r_length);
    assign w_issued_nx = w_acc ? ((w_last && r_loop) ? '0 : w_iss_inc) : r_issued;
    assign w_more      = (w_issued_nx != r_length);
    assign w_issue     = w_more && w_cred_ok;

    assign w_take  = out_valid && out_ready;
    assign w_pop   = w_take && (r_lane == LANE_W'(NLANES - 1));
    assign w_lanes = w_rdata;

    drfm_ring_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk   (M100CLK),
        .i_rst   (reset),
        .i_flush (w_stop),
        .i_wr    (w_wr),
        .i_wdata (avm_readdata),
        .i_rd    (w_pop),
        .o_rdata (w_rdata),
        .o_fill  (w_fill),
        .o_empty (w_empty)
    );

    assign out_valid      = !w_empty;
    assign out_data       = out_valid ? w_lanes[r_lane] : '0;
    assign busy           = r_busy;
    assign done           = r_done;
    assign avm_read       = r_avm_read;
    assign avm_address    = r_avm_addr;
    assign avm_byteenable = r_avm_read ? '1 : '0;

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
        end else if (w_stop) begin
            r_lane <= '0;
        end else if (w_take) begin
            r_lane <= w_pop ? '0 : r_lane + LANE_W'(1);
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_length   <= '0;
            r_loop     <= 1'b0;
            r_issued   <= '0;
            r_pending  <= '0;
            r_avm_read <= 1'b0;
            r_avm_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pending <= w_pend_nx;
            r_issued  <= w_issued_nx;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base   <= cfg_base;
                        r_length <= cfg_length;
                        r_loop   <= cfg_loop;
                        r_issued <= '0;
                        r_busy   <= 1'b1;
                        if (cfg_length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_avm_read <= 1'b1;
                            r_avm_addr <= cfg_base;
                        end
                    end
                end
                S_FETCH: begin
                    if (stop) begin
                        r_state <= S_ABORT;
                        if (!w_hold) r_avm_read <= 1'b0;
                    end else if (!w_hold) begin
                        r_avm_read <= w_issue;
                        if (w_issue) r_avm_addr <= r_base + w_issued_nx;
                        if (!w_more) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (stop) begin
                        r_state <= S_ABORT;
                    end else if (r_pending == '0 && w_empty && r_lane == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_ABORT: begin
                    // Held request must complete its handshake before we let go.
                    if (!w_hold) r_avm_read <= 1'b0;
                    if (w_pend_nx == '0 && !w_hold) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_orphan_rdv: assert property (@(posedge M100CLK) disable iff (reset)
        avm_readdatavalid |-> (r_pending != '0));

endmodule

// File: tb/tb_drfm_playback_reader.sv
// Directed bench for drfm_playback_reader with a latency-2 Avalon slave model.
module tb_drfm_playback_reader;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [24:0] cfg_base = '0, cfg_length = '0;
    logic        cfg_loop = 1'b0, start = 1'b0, stop = 1'b0;
    logic        busy, done, avm_read;
    logic [24:0] avm_address;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_cmp = 0, n_bad = 0;

    // slave / monitor state
    int          cyc = 0, acc_cnt = 0, rtn_cnt = 0, done_cnt = 0, be_err = 0, ov_after_stop = 0;
    int          first_rdv = -1, first_ov = -1;
    int          ws_at = -1, ws_len = 0, ws_done = 0, rsp_limit = 1000000;
    bit          rsp_rand = 0, stopped = 0;
    logic [24:0] acc_log[$], hold_addr[$], pend_q[$];
    int          pend_t[$];
    logic [7:0]  out_log[$];
    logic [24:0] mon_a;
    int          mon_t;

    drfm_playback_reader dut (
        .M100CLK(clk), .reset(reset),
        .cfg_base(cfg_base), .cfg_length(cfg_length), .cfg_loop(cfg_loop),
        .start(start), .stop(stop), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial forever #5 clk = ~clk;

    // Sample DUT and drive slave responses on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) out_log.push_back(out_data);
            if (done) done_cnt++;
            if (out_valid && stopped) ov_after_stop++;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (avm_byteenable !== (avm_read ? 2'b11 : 2'b00)) be_err++;
            avm_waitrequest = 1'b0;
            if (avm_read) begin
                if (acc_cnt == ws_at && ws_done < ws_len) begin
                    avm_waitrequest = 1'b1;
                    ws_done++;
                    hold_addr.push_back(avm_address);
                end else begin
                    acc_log.push_back(avm_address);
                    pend_q.push_back(avm_address);
                    pend_t.push_back(cyc);
                    acc_cnt++;
                end
            end
            avm_readdatavalid = 1'b0;
            if (pend_q.size() > 0 && cyc >= pend_t[0] + LAT && rtn_cnt < rsp_limit &&
                (!rsp_rand || $urandom_range(1, 0) == 1)) begin
                mon_a = pend_q.pop_front();
                mon_t = pend_t.pop_front();
                avm_readdata = {mon_a[7:0] ^ 8'hA5, mon_a[7:0]};
                avm_readdatavalid = 1'b1;
                rtn_cnt++;
                if (first_rdv < 0) first_rdv = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        acc_log.delete(); hold_addr.delete(); out_log.delete();
        acc_cnt = 0; rtn_cnt = 0; done_cnt = 0; be_err = 0; ov_after_stop = 0;
        first_rdv = -1; first_ov = -1; ws_at = -1; ws_len = 0; ws_done = 0;
        rsp_limit = 1000000; rsp_rand = 0; stopped = 0;
    endtask

    task automatic start_run(input logic [24:0] b, input logic [24:0] l, input logic lp);
        cfg_base = b; cfg_length = l; cfg_loop = lp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin ok = 1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, avm_read, avm_address, avm_byteenable, out_valid, out_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b addr=%h be=%b ov=%b od=%h required all 0",
                     busy, done, avm_read, avm_address, avm_byteenable, out_valid, out_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || avm_read !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b rd=%b required 0", busy, avm_read);
        end
    endtask

    task automatic test_basic();
        logic [24:0] exp_a [4] = '{25'h100, 25'h101, 25'h102, 25'h103};
        logic [7:0]  exp_b [8] = '{8'h00, 8'hA5, 8'h01, 8'hA4, 8'h02, 8'hA7, 8'h03, 8'hA6};
        bit ok;
        clear_logs();
        out_ready = 1'b1;
        cfg_base = 25'h100; cfg_length = 25'd4; cfg_loop = 1'b0;
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_start_wins: busy=%b required 1", busy); end
        wait_idle(200, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL basic_idle: busy still %b after 200 cycles, required 0", busy); end
        n_cmp++;
        if (acc_log.size() != 4) begin n_bad++; $display("FAIL basic_accepts: got %0d required 4", acc_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= acc_log.size() || acc_log[i] !== exp_a[i]) begin
                n_bad++; $display("FAIL basic_addr[%0d]: got %h required %h", i, (i < acc_log.size()) ? acc_log[i] : 25'h0, exp_a[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= out_log.size() || out_log[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL basic_byte[%0d]: got %h required %h", i, (i < out_log.size()) ? out_log[i] : 8'h0, exp_b[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_pulse: got %0d cycles required 1", done_cnt); end
        n_cmp++;
        if (first_ov - first_rdv != 1) begin n_bad++; $display("FAIL basic_latency: got %0d required 1", first_ov - first_rdv); end
        n_cmp++;
        if (be_err != 0) begin n_bad++; $display("FAIL basic_byteenable: got %0d bad cycles required 0", be_err); end
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_logs();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_stop_ignored: busy=%b required 0", busy); end
        start_run(25'h55, 25'd0, 1'b0);
        wait_idle(20, ok);
        n_cmp++;
        if (!ok || done_cnt != 1 || acc_cnt != 0) begin
            n_bad++; $display("FAIL zero_len: idle=%0d done=%0d accepts=%0d required 1/1/0", ok, done_cnt, acc_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        clear_logs();
        out_ready = 1'b0;
        start_run(25'h2000, 25'd1024, 1'b0);
        repeat (800) @(posedge clk);
        #1;
        n_cmp++;
        if (acc_cnt != 512 || avm_read !== 1'b0) begin
            n_bad++; $display("FAIL bp_stall: accepts=%0d rd=%b required 512/0", acc_cnt, avm_read);
        end
        out_ready = 1'b1;
        wait_idle(5000, ok);
        n_cmp++;
        if (!ok || acc_cnt != 1024 || out_log.size() != 2048) begin
            n_bad++; $display("FAIL bp_complete: idle=%0d accepts=%0d bytes=%0d required 1/1024/2048", ok, acc_cnt, out_log.size());
        end
        bad = 0;
        for (int i = 0; i < 1024 && 2 * i + 1 < out_log.size(); i++) begin
            if (out_log[2*i] !== 8'(i) || out_log[2*i+1] !== (8'(i) ^ 8'hA5)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL bp_data: got %0d bad words required 0", bad); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_waitrequest();
        bit ok;
        int bad;
        clear_logs();
        out_ready = 1'b1;
        ws_at = 2; ws_len = 5;
        start_run(25'h80, 25'd5, 1'b0);
        wait_idle(200, ok);
        bad = 0;
        foreach (hold_addr[i]) if (hold_addr[i] !== 25'h82) bad++;
        n_cmp++;
        if (hold_addr.size() != 5 || bad != 0) begin
            n_bad++; $display("FAIL ws_hold: held %0d cycles, %0d wrong addr; required 5/0", hold_addr.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (i >= acc_log.size() || acc_log[i] !== 25'h80 + 25'(i)) bad++;
        n_cmp++;
        if (!ok || acc_log.size() != 5 || bad != 0) begin
            n_bad++; $display("FAIL ws_accepts: idle=%0d accepts=%0d bad=%0d required 1/5/0", ok, acc_log.size(), bad);
        end
        n_cmp++;
        if (be_err != 0) begin n_bad++; $display("FAIL ws_byteenable: got %0d bad cycles required 0", be_err); end
    endtask

    task automatic test_addr_wrap();
        logic [24:0] exp_a [4] = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000, 25'h0000001};
        logic [7:0]  exp_b [8] = '{8'hFE, 8'h5B, 8'hFF, 8'h5A, 8'h00, 8'hA5, 8'h01, 8'hA4};
        bit ok;
        clear_logs();
        out_ready = 1'b1;
        start_run(25'h1FFFFFE, 25'd4, 1'b0);
        wait_idle(200, ok);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= acc_log.size() || acc_log[i] !== exp_a[i]) begin
                n_bad++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, (i < acc_log.size()) ? acc_log[i] : 25'h0, exp_a[i]);
            end
        end
        n_cmp++;
        if (out_log.size() != 8 || out_log[4] !== exp_b[4] || out_log[1] !== exp_b[1] || out_log[2] !== exp_b[2]) begin
            n_bad++; $display("FAIL wrap_bytes: got n=%0d b1=%h b2=%h b4=%h required 8/5b/ff/00",
                              out_log.size(), out_log[1], out_log[2], out_log[4]);
        end
        n_cmp++;
        if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL wrap_done: idle=%0d done=%0d required 1/1", ok, done_cnt); end
    endtask

    task automatic test_loop();
        bit ok;
        int gaps, bad;
        clear_logs();
        out_ready = 1'b1;
        start_run(25'h40, 25'd3, 1'b1);
        gaps = 0;
        repeat (12) begin
            if (!avm_read) gaps++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (gaps != 0) begin n_bad++; $display("FAIL loop_bubble: got %0d idle cycles required 0", gaps); end
        bad = 0;
        for (int i = 0; i < 9; i++) if (i >= acc_log.size() || acc_log[i] !== 25'h40 + 25'(i % 3)) bad++;
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL loop_seq: got %0d wrong addresses required 0", bad); end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; stopped = 1;
        wait_idle(100, ok);
        n_cmp++;
        if (!ok || done_cnt != 0 || ov_after_stop != 0 || pend_q.size() != 0) begin
            n_bad++; $display("FAIL loop_abort: idle=%0d done=%0d ov=%0d inflight=%0d required 1/0/0/0",
                              ok, done_cnt, ov_after_stop, pend_q.size());
        end
    endtask

    task automatic test_abort_pending();
        bit ok;
        int bad;
        clear_logs();
        out_ready = 1'b0;
        rsp_limit = 3;
        start_run(25'h500, 25'd6, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (acc_cnt != 6 || rtn_cnt != 3 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL abort_setup: accepts=%0d returns=%0d ov=%b required 6/3/1", acc_cnt, rtn_cnt, out_valid);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; stopped = 1;
        rsp_limit = 1000000; rsp_rand = 1;
        ok = 0; bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (rtn_cnt < 6 && !busy) bad++;
            if (rtn_cnt == 6) begin ok = !busy; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok || bad != 0) begin
            n_bad++; $display("FAIL abort_exit: idle_after_last=%0d early_idle=%0d required 1/0", ok, bad);
        end
        n_cmp++;
        if (ov_after_stop != 0 || done_cnt != 0) begin
            n_bad++; $display("FAIL abort_quiet: ov=%0d done=%0d required 0/0", ov_after_stop, done_cnt);
        end
        clear_logs();
        out_ready = 1'b1;
        start_run(25'h300, 25'd2, 1'b0);
        wait_idle(100, ok);
        n_cmp++;
        if (!ok || done_cnt != 1 || acc_log.size() != 2 || out_log.size() != 4 ||
            out_log[0] !== 8'h00 || out_log[1] !== 8'hA5 || out_log[2] !== 8'h01 || out_log[3] !== 8'hA4) begin
            n_bad++; $display("FAIL restart: idle=%0d done=%0d accepts=%0d bytes=%0d required 1/1/2/4 with 00 a5 01 a4",
                              ok, done_cnt, acc_log.size(), out_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_waitrequest();
        test_addr_wrap();
        test_loop();
        test_abort_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
